// File: rtl/mux16_rr_arbiter_pkg.sv
// Shared constants, state type and helpers for the mux16 round-robin arbiter.
package mux16_arb_pkg;

    localparam int N_REQ = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_t;

    // Binary requester index to one-hot grant vector.
    function automatic logic [N_REQ-1:0] onehot16(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux16_rr_arbiter_rr_pick16.sv
// Combinational rotating-priority picker: the first requester at or after
// ptr+1 (wrapping 15 -> 0) wins, so the requester at ptr ranks lowest.
module rr_pick16
    import mux16_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] winner,
    output logic             any
);

    logic [SEL_W-1:0] start;
    logic [N_REQ-1:0] rot;
    logic [SEL_W-1:0] offs;

    assign start = ptr + SEL_W'(1);
    assign any   = |req;

    // Rotate the request vector so the search origin lands at bit 0.
    always_comb begin
        logic [SEL_W-1:0] idx;
        rot = '0;
        for (int j = 0; j < N_REQ; j++) begin
            idx    = start + SEL_W'(j);
            rot[j] = req[idx];
        end
    end

    // Priority-encode the lowest set bit of the rotated vector.
    always_comb begin
        offs = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) begin
                offs = SEL_W'(j);
            end
        end
    end

    // Un-rotate: the 4-bit add wraps the index back into 0..15.
    assign winner = start + offs;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter that shares one mux16 datapath among 16 requesters.
// Owns the mux select exclusively; ownership ends on done, on the owner
// dropping its request, or when the hold limit preempts it.
module mux16_rr_arbiter
    import mux16_arb_pkg::*;
#(
    parameter int N_REQ    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant,
    output logic [SEL_W-1:0] select,
    output logic             busy
);

    // select is 4 bits wide, so the requester count cannot change.
    if (N_REQ != 16) begin : g_nreq_check
        $error("mux16_rr_arbiter: N_REQ must be 16");
    end

    localparam int HOLD_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t        state_q,    state_d;
    logic [N_REQ-1:0]  grant_q,    grant_d;
    logic [SEL_W-1:0]  select_q,   select_d;
    logic [SEL_W-1:0]  last_ptr_q, last_ptr_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic [SEL_W-1:0]  winner;
    logic              any;
    logic              at_limit;
    logic              rel;

    // While owned, last_ptr equals the owner, so the owner ranks lowest
    // when the picker re-arbitrates on release.
    rr_pick16 u_pick (
        .req    (req),
        .ptr    (last_ptr_q),
        .winner (winner),
        .any    (any)
    );

    assign at_limit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
    assign rel      = done | ~req[select_q] | at_limit;

    // Next-state logic: grant on demand, hold, hand off or go idle.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        select_d   = select_q;
        last_ptr_d = last_ptr_q;
        hold_cnt_d = hold_cnt_q;
        case (state_q)
            IDLE: begin
                if (any) begin
                    grant_d    = onehot16(winner);
                    select_d   = winner;
                    last_ptr_d = winner;
                    hold_cnt_d = '0;
                    state_d    = OWNED;
                end
            end
            OWNED: begin
                if (!rel) begin
                    if (hold_cnt_q != '1) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end else if (any) begin
                    // Back-to-back handoff; old owner wins only if alone.
                    grant_d    = onehot16(winner);
                    select_d   = winner;
                    last_ptr_d = winner;
                    hold_cnt_d = '0;
                end else begin
                    // select keeps its last value; mux output is unused.
                    grant_d    = '0;
                    hold_cnt_d = '0;
                    state_d    = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear; last_ptr=15 favours requester 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            select_q   <= '0;
            last_ptr_q <= SEL_W'(N_REQ - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            select_q   <= select_d;
            last_ptr_q <= last_ptr_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant  = grant_q;
    assign select = select_q;
    assign busy   = |grant_q;

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Directed and randomized bench for mux16_rr_arbiter (MAX_HOLD = 8).
module tb_mux16_rr_arbiter;

    localparam int WAIT_BOUND = 15 * 8 + 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        done;
    logic [15:0] grant;
    logic [3:0]  select;
    logic        busy;

    int total  = 0;
    int passed = 0;
    int failed = 0;

    int wcnt [16];
    int maxw [16];

    mux16_rr_arbiter #(
        .N_REQ    (16),
        .MAX_HOLD (8)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .done   (done),
        .grant  (grant),
        .select (select),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [15:0] nreq;
        rst_n = 1'b0;
        req   = '0;
        done  = 1'b0;

        // 1. reset state, single requester, hold until done
        do_reset();
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_select", 32'(select), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        req = 16'h0001;
        step();
        chk("t1_grant", 32'(grant), 32'h0001);
        chk("t1_select", 32'(select), 32'h0);
        chk("t1_busy", 32'(busy), 32'h1);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t1_hold", 32'(grant), 32'h0001);
        end
        done = 1'b1;
        req  = 16'h0000;
        step();
        done = 1'b0;
        chk("t1_rel_grant", 32'(grant), 32'h0);
        chk("t1_rel_busy", 32'(busy), 32'h0);
        chk("t1_rel_select", 32'(select), 32'h0);

        // done while idle is ignored
        done = 1'b1;
        step();
        done = 1'b0;
        chk("idle_done_busy", 32'(busy), 32'h0);

        // 2. all requesting, done every cycle -> 0..15,0 without bubbles
        do_reset();
        req  = 16'hFFFF;
        done = 1'b1;
        for (int i = 0; i < 17; i++) begin
            step();
            chk("t2_select", 32'(select), 32'(i % 16));
            chk("t2_busy", 32'(busy), 32'h1);
        end
        done = 1'b0;
        req  = 16'h0000;

        // 3. hold-limit preemption alternates 0 and 4 every 8 cycles
        do_reset();
        req = 16'h0011;
        for (int e = 1; e <= 24; e++) begin
            step();
            chk("t3_select", 32'(select), (((e - 1) / 8) % 2 == 1) ? 32'h4 : 32'h0);
        end
        req = 16'h0000;

        // 4. owner drops req: handoff to 9, later idle with select kept at 5
        do_reset();
        req = 16'h0220;
        step();
        chk("t4_first", 32'(select), 32'h5);
        req = 16'h0200;
        step();
        chk("t4_handoff", 32'(select), 32'h9);
        chk("t4_handoff_grant", 32'(grant), 32'h0200);
        req = 16'h0000;
        step();
        chk("t4_idle_busy", 32'(busy), 32'h0);
        req = 16'h0020;
        step();
        chk("t4_owner5", 32'(grant), 32'h0020);
        req = 16'h0000;
        step();
        chk("t4_drop_busy", 32'(busy), 32'h0);
        chk("t4_drop_grant", 32'(grant), 32'h0);
        chk("t4_drop_select", 32'(select), 32'h5);

        // 5. asynchronous reset mid-grant, then requester 0 favoured
        req = 16'h0020;
        step();
        chk("t5_owner5", 32'(grant), 32'h0020);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_grant", 32'(grant), 32'h0);
        chk("t5_async_busy", 32'(busy), 32'h0);
        chk("t5_async_select", 32'(select), 32'h0);
        step();
        rst_n = 1'b1;
        req   = 16'h8001;
        step();
        chk("t5_first0", 32'(select), 32'h0);
        chk("t5_first0_grant", 32'(grant), 32'h0001);
        done = 1'b1;
        step();
        chk("t5_next15", 32'(select), 32'hF);
        step();
        chk("t5_wrap0", 32'(select), 32'h0);
        done = 1'b0;

        // 6. random traffic with invariants and starvation bound
        do_reset();
        for (int i = 0; i < 16; i++) begin
            wcnt[i] = 0;
            maxw[i] = 0;
        end
        for (int c = 0; c < 10000; c++) begin
            step();
            chk("inv_onehot0", 32'($onehot0(grant)), 32'h1);
            chk("inv_busy", 32'(busy), 32'(|grant));
            chk("inv_grant_sel", 32'(grant[select]), 32'(busy));
            for (int i = 0; i < 16; i++) begin
                if (req[i] && !grant[i]) wcnt[i]++;
                else wcnt[i] = 0;
                if (wcnt[i] > maxw[i]) maxw[i] = wcnt[i];
            end
            nreq = req;
            for (int i = 0; i < 16; i++) begin
                if (grant[i]) begin
                    if ($urandom_range(7) == 0) nreq[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(3) == 0) nreq[i] = 1'b1;
                end
            end
            req  = nreq;
            done = busy && ($urandom_range(3) == 0);
        end
        for (int i = 0; i < 16; i++) begin
            chk("max_wait", 32'(maxw[i] <= WAIT_BOUND), 32'h1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
